// File: rtl/sfx_mixer_if.sv
// Mixer control / ROM / audio bus. The master drives requests and ROM data,
// and the mixer (slave) drives ROM addresses and the mixed audio.
interface sfx_mixer_if #(
    parameter int NUM_SFX = 3,
    parameter int W       = 16,
    parameter int AW      = 17
);
    logic                        sample_req;
    logic [NUM_SFX-1:0]          trigger;
    logic [NUM_SFX*AW-1:0]       sfx_len;
    logic                        mute;
    logic [1:0]                  bgm_shift;
    logic [(NUM_SFX+1)*AW-1:0]   rom_addr;
    logic [(NUM_SFX+1)*W-1:0]    rom_data;
    logic [W-1:0]                audio_output;
    logic                        audio_valid;
    logic [NUM_SFX-1:0]          busy;

    modport master (
        output sample_req, trigger, sfx_len, mute, bgm_shift, rom_data,
        input  rom_addr, audio_output, audio_valid, busy
    );

    modport slave (
        input  sample_req, trigger, sfx_len, mute, bgm_shift, rom_data,
        output rom_addr, audio_output, audio_valid, busy
    );
endinterface

// File: rtl/sfx_mixer.sv
// Background loop plus NUM_SFX one-shot voices, mixed with saturation.
// Each output sample takes two cycles: address phase, then ROM capture.
module sfx_mixer #(
    parameter int NUM_SFX = 3,
    parameter int W       = 16,
    parameter int AW      = 17,
    parameter int BGM_LEN = 120001
) (
    input logic       clk,
    input logic       reset,
    sfx_mixer_if.slave bus
);
    localparam int SW = W + 3;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] BGM_LAST = AW'(BGM_LEN - 1);

    logic                          req_pend;
    logic                          accept;
    logic                          capture;
    logic [AW-1:0]                 bgm_addr;
    logic [NUM_SFX-1:0]            play;
    logic [NUM_SFX-1:0][AW-1:0]    vaddr;
    logic [NUM_SFX-1:0][W-1:0]     contrib;
    logic signed [W-1:0]           bgm_s;
    logic signed [SW-1:0]          sum;
    logic [W-1:0]                  mix;

    // A request blocks a new one during its capture cycle.
    assign accept  = bus.sample_req & ~req_pend;
    assign capture = req_pend;

    always_ff @(posedge clk) begin
        if (!reset) req_pend <= 1'b0;
        else        req_pend <= accept;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            bgm_addr <= '0;
        else if (capture)
            bgm_addr <= (bgm_addr == BGM_LAST) ? '0 : bgm_addr + ONE;
    end

    for (genvar i = 0; i < NUM_SFX; i++) begin : g_voice
        logic [0:0]    state;
        logic [AW-1:0] addr;
        logic [AW-1:0] len_q;
        logic [AW-1:0] len_in;

        assign len_in = bus.sfx_len[i*AW +: AW];

        // Trigger wins over advance/end-of-clip so a retrigger restarts cleanly.
        always_ff @(posedge clk) begin
            if (!reset) begin
                state <= IDLE;
                addr  <= '0;
                len_q <= '0;
            end else if (bus.trigger[i] && len_in != '0) begin
                state <= PLAY;
                addr  <= '0;
                len_q <= len_in;
            end else if (capture && state == PLAY) begin
                if (addr == len_q - ONE) begin
                    state <= IDLE;
                    addr  <= '0;
                end else begin
                    addr <= addr + ONE;
                end
            end
        end

        assign play[i]    = (state == PLAY);
        assign vaddr[i]   = addr;
        assign contrib[i] = play[i] ? bus.rom_data[(i+1)*W +: W] : '0;
    end

    assign bus.rom_addr = {vaddr, bgm_addr};
    assign bus.busy     = play;

    always_comb begin
        bgm_s = $signed(bus.rom_data[W-1:0]) >>> bus.bgm_shift;
        sum   = bus.mute ? '0 : SW'(bgm_s);
        for (int i = 0; i < NUM_SFX; i++)
            sum = sum + SW'($signed(contrib[i]));
    end

    // Fits in W bits iff the top guard bits all agree with the sign bit.
    always_comb begin
        if (sum[SW-1:W-1] == '0 || sum[SW-1:W-1] == '1)
            mix = sum[W-1:0];
        else if (sum[SW-1])
            mix = {1'b1, {(W-1){1'b0}}};
        else
            mix = {1'b0, {(W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.audio_output <= '0;
            bus.audio_valid  <= 1'b0;
        end else begin
            bus.audio_valid <= capture;
            if (capture) bus.audio_output <= mix;
        end
    end
endmodule
